// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
package ro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    COUNT,
    DONE
  } ro_state_t;

  localparam int RO_CNT_W_DEF   = 20;
  localparam int RO_WIN_W_DEF   = 16;
  localparam int RO_WARMUP_DEF  = 16;

  // All-ones value for a counter of the given width (widths above 31 clamp to 32 bits).
  function automatic logic [31:0] RO_CNT_MAX(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Multi-stage synchroniser for the asynchronous RO output plus a rising-edge
// detector producing a one-cycle pulse in the clk domain.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ro_freq_counter.sv
// Gates a ring oscillator, counts its rising edges over a programmable window
// and returns the count over valid/ready. Define RO_FREQ_CONT_EN for back-to-back windows.
module ro_freq_counter
  import ro_pkg::*;
#(
  parameter int CNT_W         = RO_CNT_W_DEF,
  parameter int WIN_W         = RO_WIN_W_DEF,
  parameter int WARMUP_CYCLES = RO_WARMUP_DEF,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] winLen,
  output logic             busy,
  output logic             roEnable,
  input  logic             roOut,
  output logic [CNT_W-1:0] count,
  output logic             countValid,
  input  logic             countReady,
  output logic             saturated
);

  localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RO_CNT_MAX(CNT_W));

  ro_state_t        r_state;
  ro_state_t        w_state_nxt;
  logic [WIN_W-1:0] r_win_len;
  logic [WIN_W-1:0] r_win_cnt;
  logic [WU_W-1:0]  r_warm_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] w_edge_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic             w_pulse;
  logic             w_accept;
  logic             w_warm_last;
  logic             w_win_last;
  logic             w_restart;

  ro_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (roOut),
    .o_pulse (w_pulse)
  );

  assign w_accept    = (r_state == IDLE) && start;
  assign w_warm_last = (r_warm_cnt == WU_W'(WARMUP_CYCLES - 1));
  assign w_win_last  = (r_win_cnt == r_win_len - WIN_W'(1));
  assign w_edge_nxt  = (w_pulse && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

`ifdef RO_FREQ_CONT_EN
  // A start raised during the handshake is the request to leave continuous mode.
  assign w_restart = (r_state == DONE) && countReady && !start;
  assign roEnable  = (r_state != IDLE);
`else
  assign w_restart = 1'b0;
  assign roEnable  = (r_state == WARMUP) || (r_state == COUNT);
`endif

  assign busy       = (r_state != IDLE);
  assign countValid = (r_state == DONE);
  assign count      = r_count;
  assign saturated  = r_sat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start)       w_state_nxt = WARMUP;
      WARMUP:  if (w_warm_last) w_state_nxt = COUNT;
      COUNT:   if (w_win_last)  w_state_nxt = DONE;
      DONE:    if (countReady)  w_state_nxt = w_restart ? COUNT : IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_warm_cnt <= '0;
      r_win_cnt  <= '0;
      r_count    <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_accept || w_restart) begin
        r_warm_cnt <= '0;
        r_win_cnt  <= '0;
        r_sat      <= 1'b0;
      end else if (r_state == WARMUP) begin
        r_warm_cnt <= r_warm_cnt + WU_W'(1);
        r_win_cnt  <= '0;
      end else if (r_state == COUNT) begin
        r_win_cnt <= r_win_cnt + WIN_W'(1);
        // The result register only moves on entry to DONE, so the old result stays visible meanwhile.
        if (w_win_last) begin
          r_count <= w_edge_nxt;
          r_sat   <= (w_edge_nxt == CNT_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_win_len <= (winLen == '0) ? WIN_W'(1) : winLen;
    if (w_accept || w_restart) r_edge_cnt <= '0;
    else if (r_state == COUNT) r_edge_cnt <= w_edge_nxt;
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: clk-aligned square waves on roOut,
// expected counts from windows that span whole wave periods.
module tb_ro_freq_counter;

  localparam int WARMUP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        countReady = 1'b0;
  logic        roOut = 1'b0;
  logic [15:0] winLen = '0;

  logic        busy, roEnable, countValid, saturated;
  logic [19:0] count;
  logic        busy4, roEnable4, countValid4, saturated4;
  logic [3:0]  count4;

  int hi_len = 2;
  int lo_len = 2;
  bit hold = 1'b0;
  bit hold_lvl = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  ro_freq_counter #(.CNT_W(20), .WIN_W(16), .WARMUP_CYCLES(WARMUP), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .winLen(winLen), .busy(busy),
    .roEnable(roEnable), .roOut(roOut), .count(count), .countValid(countValid),
    .countReady(countReady), .saturated(saturated)
  );

  ro_freq_counter #(.CNT_W(4), .WIN_W(16), .WARMUP_CYCLES(WARMUP), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .start(start), .winLen(winLen), .busy(busy4),
    .roEnable(roEnable4), .roOut(roOut), .count(count4), .countValid(countValid4),
    .countReady(countReady), .saturated(saturated4)
  );

  always #5 clk = ~clk;

  // Square-wave source, changing half a clock away from the sampling edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (hold) roOut = hold_lvl;
      else begin
        roOut = (ph < hi_len);
        ph = ph + 1;
        if (ph >= hi_len + lo_len) ph = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_wave(input int h, input int l);
    hi_len = h;
    lo_len = l;
    hold = 1'b0;
  endtask

  task automatic start_meas(input int wl);
    winLen = wl[15:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 1;
    while (countValid !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // period==0 means roOut is static, so no edges are expected.
  task automatic measure(input string tag, input int wl, input int period, input bit bp);
    int wl_eff, edges, n;
    logic [31:0] exp4;
    wl_eff = (wl == 0) ? 1 : wl;
    edges  = (period == 0) ? 0 : wl_eff / period;
    exp4   = (edges > 15) ? 32'd15 : 32'(edges);
    start_meas(wl);
    chk({tag, " busy_warmup"}, 32'(busy), 1);
    chk({tag, " roen_warmup"}, 32'(roEnable), 1);
    wait_valid(1 + WARMUP + wl_eff + 10, n);
    chk({tag, " latency"}, 32'(n), 32'(1 + WARMUP + wl_eff));
    chk({tag, " count"}, 32'(count), 32'(edges));
    chk({tag, " sat"}, 32'(saturated), 0);
    chk({tag, " valid4"}, 32'(countValid4), 1);
    chk({tag, " count4"}, 32'(count4), exp4);
    chk({tag, " sat4"}, 32'(saturated4), (edges >= 15) ? 1 : 0);
    chk({tag, " roen_done"}, 32'(roEnable), 0);
    if (bp) begin
      for (int i = 0; i < 50; i++) begin
        start = (i % 7 == 3);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " bp_valid"}, 32'(countValid), 1);
        chk({tag, " bp_count"}, 32'(count), 32'(edges));
        chk({tag, " bp_roen"}, 32'(roEnable), 0);
      end
      start = 1'b1;
    end
    countReady = 1'b1;
    @(posedge clk); #1;
    countReady = 1'b0;
    start = 1'b0;
    chk({tag, " idle_busy"}, 32'(busy), 0);
    chk({tag, " idle_valid"}, 32'(countValid), 0);
    if (bp) begin
      @(posedge clk); #1;
      chk({tag, " start_ignored"}, 32'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset roEnable", 32'(roEnable), 0);
    chk("reset count", 32'(count), 0);
    chk("reset countValid", 32'(countValid), 0);
    chk("reset saturated", 32'(saturated), 0);
    repeat (3) @(posedge clk);
    #1;

`ifdef RO_FREQ_CONT_EN
    begin
      int n;
      set_wave(2, 2);
      countReady = 1'b1;
      start_meas(100);
      wait_valid(140, n);
      chk("cont first latency", 32'(n), 117);
      for (int k = 0; k < 4; k++) begin
        chk("cont count", 32'(count), 25);
        chk("cont roen_done", 32'(roEnable), 1);
        @(posedge clk); #1;
        wait_valid(120, n);
        chk("cont period", 32'(n), 101);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      countReady = 1'b0;
      chk("cont stop busy", 32'(busy), 0);
      chk("cont stop roen", 32'(roEnable), 0);
    end
`else
    set_wave(2, 2);
    measure("w100_p4", 100, 4, 1'b0);
    set_wave(5, 5);
    measure("w1000_p10", 1000, 10, 1'b0);
    set_wave(2, 2);
    measure("w200_p4", 200, 4, 1'b0);
    measure("w20_p4", 20, 4, 1'b0);
    measure("backpressure", 100, 4, 1'b1);

    // Abort 40 cycles into a 100-cycle window.
    start_meas(100);
    repeat (WARMUP + 40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst roEnable", 32'(roEnable), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst countValid", 32'(countValid), 0);
    chk("midrst count", 32'(count), 0);
    chk("midrst count4", 32'(count4), 0);
    measure("after_rst", 100, 4, 1'b0);

    hold_lvl = 1'b1;
    hold = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    measure("winlen0", 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int h, l, m;
      h = $urandom_range(1, 6);
      l = $urandom_range(1, 6);
      m = $urandom_range(1, 40);
      set_wave(h, l);
      measure("random", m * (h + l), h + l, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Measurement stage directly downstream of a chained inverting delay path such as a 50-stage ro_33n chain.
- Gates the ring-oscillator loop through roEnable and synchronises the oscillating path output into the system clock domain.
- Counts rising edges over a programmable window of clock cycles and returns the count through a valid/ready handshake.
- The edge count is the frequency sample the FPGA-spy logic uses to infer delay changes.

Parameters:
- CNT_W, 20: width of the edge counter and count output.
- WIN_W, 16: width of the window-length input, in clock cycles.
- WARMUP_CYCLES, 16: cycles roEnable is held high before counting starts, so the oscillation can settle.
- SYNC_STAGES, 2: flip-flop stages in the roOut synchroniser; minimum 2.

Ports:
- clk, input, 1: system clock; the only clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to begin a measurement.
- winLen, input, WIN_W: window length in clocks; sampled on the cycle start is accepted.
- busy, output, 1: high in every state except IDLE.
- roEnable, output, 1: drives the enable/NAND gate that closes the RO loop (the chain's pathInput side).
- roOut, input, 1: asynchronous oscillating output of the chain (pathResult).
- count, output, CNT_W: rising edges counted in the window; stable while countValid is high.
- countValid, output, 1: result available.
- countReady, input, 1: consumer accepts the result.
- saturated, output, 1: the counter hit its maximum during this window; qualified by countValid.

Behaviour:
- Reset values: busy=0, roEnable=0, count=0, countValid=0, saturated=0. Reset also clears the synchroniser, the edge-detect register, the window counter and the warm-up counter; the FSM goes to IDLE.
- Reset mid-operation aborts at once. roEnable drops on the cycle after rst is sampled.
- FSM states:
  - IDLE: roEnable=0. On start=1, latch winLen (0 is treated as 1), clear the edge counter, go to WARMUP.
  - WARMUP: roEnable=1 for exactly WARMUP_CYCLES cycles, then go to COUNT. The synchroniser and edge detector run but edges are not counted.
  - COUNT: roEnable=1 for exactly the latched winLen cycles. Each cycle where the synchronised roOut is 1 and its previous sampled value is 0 increments the edge counter by 1.
  - COUNT exit: on the last window cycle, go to DONE; an edge detected on that last cycle is counted.
  - DONE: roEnable=0, countValid=1, and count and saturated are held. When countValid and countReady are both 1 in the same cycle, the result is consumed: go to IDLE and drop countValid the next cycle.
- start while busy=1 is ignored; there is no queuing.
- start in the same cycle as a DONE handshake is ignored; it must be reissued in IDLE.
- Saturation: when the counter reaches 2^CNT_W-1 it holds that value and sets saturated. saturated clears when the next measurement starts.
- Measurement limits:
  - Edges are resolvable only when the roOut high and low phases each last at least one clock; faster signals alias, and this is documented rather than detected.
  - The synchroniser adds SYNC_STAGES cycles of latency between roOut and edge detection.
- Latency from start to countValid: 1 + WARMUP_CYCLES + winLen cycles.
- The count output register loads only on the transition into DONE, so count holds the previous result while a new measurement runs.

Optional Feature:
- Macro: RO_FREQ_CONT_EN.
- With the macro defined: the handshake in DONE returns to COUNT, not IDLE. The edge counter is cleared, the same winLen is reused, and WARMUP is skipped. roEnable stays high through DONE in this mode.
- With the macro defined, continuous operation stops when start is high during the handshake cycle; the FSM then returns to IDLE.
- Without the macro: single-shot behaviour exactly as above.

Decomposition:
- Shared package ro_pkg:
  - FSM state enum: IDLE, WARMUP, COUNT, DONE.
  - Default CNT_W, WIN_W and WARMUP_CYCLES constants.
  - RO_CNT_MAX helper function.
- Sub-module ro_edge_sync: SYNC_STAGES-deep synchroniser plus rising-edge detector. Output is a one-cycle pulse; reset clears all stages to 0.

Test Plan:
- Bench drives roOut as a clk-aligned square wave (2 high, 2 low). WARMUP_CYCLES=16, winLen=100, start pulse. Required: countValid rises exactly 117 cycles after start; count=25; saturated=0.
- Slower wave (5 high, 5 low), winLen=1000. Required: count=100.
- CNT_W=4, winLen=200, 2/2 wave. Required: count=15, saturated=1. A following measurement with winLen=20 gives count=5 and saturated=0.
- Backpressure: countReady held 0 for 50 cycles in DONE. Required: count and countValid stable and roEnable=0 throughout; start pulses during this period are ignored; the FSM returns to IDLE the cycle after countReady=1.
- Reset mid-COUNT (cycle 40 of 100). Required: next cycle roEnable=0, busy=0, countValid=0, count=0. A fresh start then yields count=25.
- winLen=0 with roOut held at 1. Required: window of 1 cycle, count=0. Under RO_FREQ_CONT_EN, with the 2/2 wave and countReady=1, results arrive every 101 cycles with count=25 until start is asserted during the handshake.
